// File: rtl/pipelined_shifter.sv
// pipelined_shifter: parametrised barrel shifter (SRL/SLL/SRA, optional ROR).
// The shifter uses log2(WIDTH) mux levels. A register stage follows every
// REG_EVERY levels. Both sides use a valid/ready handshake, and the pipeline
// sustains full throughput under backpressure. A tag is carried alongside
// each request, and a flush input squashes every request in flight.
// Optional feature macro: SHIFTER_ROTATE_EN builds the rotate-right wrap path
// for op 11. When the macro is undefined, op 11 behaves as SRL.
module pipelined_shifter #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 5,
  localparam int SHAMT_W  = $clog2(WIDTH),
  localparam int L        = (SHAMT_W + REG_EVERY - 1) / REG_EVERY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFTER_ROTATE_EN
  localparam logic [1:0] OP_ROR = 2'b11;
`endif

  // Per-stage state: valid, partial data, shift amount, op, SRA sign and tag
  logic [L-1:0]       valid_q;
  logic [WIDTH-1:0]   data_q  [L];
  logic [WIDTH-1:0]   data_d  [L];
  logic [SHAMT_W-1:0] shamt_q [L];
  logic [SHAMT_W-1:0] shamt_d [L];
  logic [1:0]         op_q    [L];
  logic [1:0]         op_d    [L];
  logic               sign_q  [L];
  logic               sign_d  [L];
  logic [TAG_W-1:0]   tag_q   [L];
  logic [TAG_W-1:0]   tag_d   [L];
  logic [L-1:0]       stageLoad;

  function automatic logic [WIDTH-1:0] reverseBits(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  // A single mux level: shift right by amt. The bits vacated at the top are
  // filled with the carried sign for SRA, or with the bits that wrapped out
  // of the bottom for ROR.
  function automatic logic [WIDTH-1:0] shiftLevel(input logic [WIDTH-1:0] d,
                                                  input int amt,
                                                  input logic [1:0] op,
                                                  input logic sign);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] fillMask;
    fillMask = ~({WIDTH{1'b1}} >> amt);
    r = d >> amt;
    if (op == OP_SRA && sign) r = r | fillMask;
`ifdef SHIFTER_ROTATE_EN
    if (op == OP_ROR) r = r | (d << (WIDTH - amt));
`endif
    return r;
  endfunction

  // Applies the mux levels that belong to stage s. The last stage also undoes
  // the entry bit-reversal for SLL, so the output register holds the final
  // result directly.
  function automatic logic [WIDTH-1:0] stageLevels(input logic [WIDTH-1:0] d,
                                                   input int s,
                                                   input logic [SHAMT_W-1:0] sh,
                                                   input logic [1:0] op,
                                                   input logic sign);
    logic [WIDTH-1:0] r;
    r = d;
    for (int k = 0; k < SHAMT_W; k++) begin
      if ((k / REG_EVERY) == s && sh[k]) r = shiftLevel(r, 1 << k, op, sign);
    end
    if (s == L - 1 && op == OP_SLL) r = reverseBits(r);
    return r;
  endfunction

  // Handshake chain: a stage loads when it is empty or when its contents move
  // downstream in the same cycle. Evaluating from the output back to the input
  // lets bubbles collapse even while the output is stalled.
  always_comb begin
    logic [L-1:0] moveV;
    logic [L-1:0] loadV;
    moveV = '0;
    loadV = '0;
    moveV[L-1] = valid_q[L-1] && out_ready;
    loadV[L-1] = !valid_q[L-1] || moveV[L-1];
    for (int s = L - 2; s >= 0; s--) begin
      moveV[s] = valid_q[s] && loadV[s+1];
      loadV[s] = !valid_q[s] || moveV[s];
    end
    stageLoad = loadV;
    in_ready  = !flush && loadV[0];
  end

  // Next-state datapath for every stage. Stage 0 takes the operand (reversed
  // for SLL) and captures the SRA sign. Later stages take the stage ahead.
  always_comb begin
    data_d[0]  = stageLevels((in_op == OP_SLL) ? reverseBits(in_data) : in_data,
                             0, in_shamt, in_op, in_data[WIDTH-1]);
    shamt_d[0] = in_shamt;
    op_d[0]    = in_op;
    sign_d[0]  = in_data[WIDTH-1];
    tag_d[0]   = in_tag;
    for (int s = 1; s < L; s++) begin
      data_d[s]  = stageLevels(data_q[s-1], s, shamt_q[s-1], op_q[s-1], sign_q[s-1]);
      shamt_d[s] = shamt_q[s-1];
      op_d[s]    = op_q[s-1];
      sign_d[s]  = sign_q[s-1];
      tag_d[s]   = tag_q[s-1];
    end
  end

  // Stage registers. Reset clears everything. Flush only drops the valid bits.
  // A stage's payload is written only when real data arrives from upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < L; s++) begin
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        op_q[s]    <= '0;
        sign_q[s]  <= 1'b0;
        tag_q[s]   <= '0;
      end
    end else begin
      if (flush) begin
        valid_q[0] <= 1'b0;
      end else if (stageLoad[0]) begin
        valid_q[0] <= in_valid && in_ready;
      end
      if (stageLoad[0] && in_valid && in_ready) begin
        data_q[0]  <= data_d[0];
        shamt_q[0] <= shamt_d[0];
        op_q[0]    <= op_d[0];
        sign_q[0]  <= sign_d[0];
        tag_q[0]   <= tag_d[0];
      end
      for (int s = 1; s < L; s++) begin
        if (flush) begin
          valid_q[s] <= 1'b0;
        end else if (stageLoad[s]) begin
          valid_q[s] <= valid_q[s-1];
        end
        if (stageLoad[s] && valid_q[s-1]) begin
          data_q[s]  <= data_d[s];
          shamt_q[s] <= shamt_d[s];
          op_q[s]    <= op_d[s];
          sign_q[s]  <= sign_d[s];
          tag_q[s]   <= tag_d[s];
        end
      end
    end
  end

  assign out_valid = valid_q[L-1];
  assign out_data  = data_q[L-1];
  assign out_tag   = tag_q[L-1];

endmodule
